occupancy_gate_ctrl: RTL and testbench

Occupancy controller that sits behind the two-sensor entry/exit sequence detector and turns its single-cycle ENTRY/EXIT event pulses into a managed room occupancy. It keeps the count and drives the LED count outputs. It owns the door-lock decision, with capacity limit and hysteresis, and flags illegal events: entry while full, exit while empty. It is the block that decides whether a detected passage is accepted, and it is the only writer of the occupancy count.

---
 rtl/occ_pkg.sv | 19 +
 rtl/occ_alarm_timer.sv | 42 ++++
 rtl/occupancy_gate_ctrl.sv | 111 +++++++++++
 tb/tb_occupancy_gate_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/occ_pkg.sv
// Shared types and helpers for the occupancy gate controller.
// Holds the FSM state encoding, the default count width and the alarm timer width helper.
package occ_pkg;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } occ_state_e;

  localparam int OCC_WIDTH = 4;

  // Bits needed to hold the value 'cycles' (never less than one bit).
  function automatic int timer_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/occ_alarm_timer.sv
// Retriggerable alarm timer: a load starts (or restarts) a busy window of CYCLES clocks,
// beginning on the clock after the load; clear stops it at once.
module occ_alarm_timer
  import occ_pkg::*;
#(
  parameter int CYCLES = 100
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  input  logic load,
  output logic busy
);

  localparam int TW = timer_width(CYCLES);
  localparam logic [TW-1:0] LOAD_VAL = TW'(CYCLES);
  localparam logic [TW-1:0] LAST_VAL = TW'(1);

  logic [TW-1:0] remain_q;
  logic          busy_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      remain_q <= '0;
      busy_q   <= 1'b0;
    end else if (clear) begin
      remain_q <= '0;
      busy_q   <= 1'b0;
    end else if (load) begin
      remain_q <= LOAD_VAL;
      busy_q   <= 1'b1;
    end else begin
      if (remain_q != '0) remain_q <= remain_q - 1'b1;
      // Busy covers remain values CYCLES..1, i.e. exactly CYCLES clocks.
      busy_q <= (remain_q > LAST_VAL);
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/occupancy_gate_ctrl.sv
// Occupancy controller: turns ENTRY/EXIT pulses into a saturating room count with a hysteretic
// door lock and sticky overflow/underflow flags. Define OCC_ALARM_EN to add the timed ALARM output.
module occupancy_gate_ctrl
  import occ_pkg::*;
#(
  parameter int MAX_COUNT    = 15,
  parameter int HYST         = 2,
  parameter int WIDTH        = OCC_WIDTH,
  parameter int ALARM_CYCLES = 100
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENTRY_P,
  input  logic             EXIT_P,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] COUNT,
  output logic             EMPTY,
  output logic             LOCK,
  output logic             OVF_ERR,
  output logic             UNF_ERR,
  output logic             ALARM
);

  if (MAX_COUNT < 2 || MAX_COUNT > (1 << WIDTH) - 1 || HYST < 1 || HYST >= MAX_COUNT ||
      ALARM_CYCLES < 1) begin : g_bad_params
    $error("occupancy_gate_ctrl: illegal parameter combination");
  end

  localparam logic [WIDTH-1:0] FULL_LVL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] OPEN_LVL = WIDTH'(MAX_COUNT - HYST);

  occ_state_e       state_q, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             empty_q;
  logic             ovf_q, ovf_nxt;
  logic             unf_q, unf_nxt;
  logic             reject;

  // NOTE: every always_comb output is defaulted first so no path leaves a latch behind.
  always_comb begin
    count_nxt = count_q;
    ovf_nxt   = ovf_q;
    unf_nxt   = unf_q;
    reject    = 1'b0;
    state_nxt = state_q;

    if (CLEAR) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
    end else if (ENTRY_P && !EXIT_P) begin
      if (state_q == ST_LOCKED) begin
        ovf_nxt = 1'b1;
        reject  = 1'b1;
      end else begin
        count_nxt = count_q + 1'b1;
      end
    end else if (EXIT_P && !ENTRY_P) begin
      if (count_q != '0) count_nxt = count_q - 1'b1;
      else               unf_nxt   = 1'b1;
    end

    // Lock decisions look at the post-event count so LOCK moves in step with COUNT.
    if (CLEAR) begin
      state_nxt = ST_OPEN;
    end else begin
      case (state_q)
        ST_OPEN:   if (count_nxt == FULL_LVL) state_nxt = ST_LOCKED;
        ST_LOCKED: if (count_nxt <= OPEN_LVL) state_nxt = ST_OPEN;
        default:   state_nxt = ST_OPEN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_OPEN;
      count_q <= '0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  assign COUNT   = count_q;
  assign EMPTY   = empty_q;
  assign LOCK    = (state_q == ST_LOCKED);
  assign OVF_ERR = ovf_q;
  assign UNF_ERR = unf_q;

`ifdef OCC_ALARM_EN
  occ_alarm_timer #(
    .CYCLES(ALARM_CYCLES)
  ) u_alarm_timer (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clear(CLEAR),
    .load (reject),
    .busy (ALARM)
  );
`else
  assign ALARM = 1'b0;
`endif

endmodule

// File: tb/tb_occupancy_gate_ctrl.sv
// Self-checking bench for occupancy_gate_ctrl (MAX_COUNT=4, HYST=2, ALARM_CYCLES=8).
// Expected outputs are queued when a cycle's stimulus is driven and popped after the clock edge.
module tb_occupancy_gate_ctrl;

  localparam int MAXC  = 4;
  localparam int HYSTC = 2;
  localparam int W     = 4;
  localparam int ACYC  = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         ENTRY_P = 1'b0;
  logic         EXIT_P = 1'b0;
  logic         CLEAR = 1'b0;
  logic [W-1:0] COUNT;
  logic         EMPTY, LOCK, OVF_ERR, UNF_ERR, ALARM;

  occupancy_gate_ctrl #(
    .MAX_COUNT   (MAXC),
    .HYST        (HYSTC),
    .WIDTH       (W),
    .ALARM_CYCLES(ACYC)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .ENTRY_P(ENTRY_P),
    .EXIT_P (EXIT_P),
    .CLEAR  (CLEAR),
    .COUNT  (COUNT),
    .EMPTY  (EMPTY),
    .LOCK   (LOCK),
    .OVF_ERR(OVF_ERR),
    .UNF_ERR(UNF_ERR),
    .ALARM  (ALARM)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int count;
    int empty;
    int lock;
    int ovf;
    int unf;
    int alarm;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural reference state.
  int m_count, m_locked, m_ovf, m_unf, m_alarm_left;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_locked = 0; m_ovf = 0; m_unf = 0; m_alarm_left = 0;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.count = m_count;
    e.empty = (m_count == 0) ? 1 : 0;
    e.lock  = m_locked;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
`ifdef OCC_ALARM_EN
    e.alarm = (m_alarm_left > 0) ? 1 : 0;
`else
    e.alarm = 0;
`endif
    return e;
  endfunction

  task automatic model_step(input bit en, input bit ex, input bit clr);
    bit rejected;
    rejected = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      if (en && !ex) begin
        if (m_locked != 0) begin
          m_ovf = 1;
          rejected = 1'b1;
        end else begin
          m_count++;
        end
      end else if (ex && !en) begin
        if (m_count > 0) m_count--;
        else m_unf = 1;
      end
      if (m_locked == 0 && m_count == MAXC) m_locked = 1;
      else if (m_locked != 0 && m_count <= MAXC - HYSTC) m_locked = 0;
      if (rejected) m_alarm_left = ACYC;
      else if (m_alarm_left > 0) m_alarm_left--;
    end
  endtask

  task automatic compare_now(input string tag, input exp_t e);
    check({tag, ".count"}, int'(COUNT), e.count);
    check({tag, ".empty"}, int'(EMPTY), e.empty);
    check({tag, ".lock"},  int'(LOCK),  e.lock);
    check({tag, ".ovf"},   int'(OVF_ERR), e.ovf);
    check({tag, ".unf"},   int'(UNF_ERR), e.unf);
    check({tag, ".alarm"}, int'(ALARM), e.alarm);
  endtask

  // One clock of stimulus: queue the expectation, clock, then pop and compare.
  task automatic step(input string tag, input bit en, input bit ex, input bit clr);
    exp_t e;
    ENTRY_P = en;
    EXIT_P  = ex;
    CLEAR   = clr;
    model_step(en, ex, clr);
    sb_q.push_back(model_outputs());
    @(posedge CLK);
    #1;
    ENTRY_P = 1'b0;
    EXIT_P  = 1'b0;
    CLEAR   = 1'b0;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      compare_now(tag, e);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    compare_now("reset", model_outputs());
    @(negedge CLK);
    RST_N = 1'b1;

    // Fill to capacity, pulses 10 cycles apart.
    for (int k = 0; k < MAXC; k++) begin
      step("fill", 1'b1, 1'b0, 1'b0);
      idle("fill_gap", 9);
    end

    // Entry while full is rejected and starts the alarm.
    step("ovf_entry", 1'b1, 1'b0, 1'b0);
    idle("alarm_win", ACYC + 3);

    // Hysteresis on the way down, then a re-entry.
    step("exit_4to3", 1'b0, 1'b1, 1'b0);
    step("exit_3to2", 1'b0, 1'b1, 1'b0);
    step("entry_2to3", 1'b1, 1'b0, 1'b0);

    // Drain to zero, then underflow, simultaneous pulses, clear.
    for (int k = 0; k < 3; k++) step("drain", 1'b0, 1'b1, 1'b0);
    step("unf_exit", 1'b0, 1'b1, 1'b0);
    step("both_at_0", 1'b1, 1'b1, 1'b0);
    step("clear_err", 1'b0, 1'b0, 1'b1);

    // Refill, reject twice with a re-trigger mid-window.
    for (int k = 0; k < MAXC; k++) step("refill", 1'b1, 1'b0, 1'b0);
    step("rej1", 1'b1, 1'b0, 1'b0);
    idle("rej_gap", 3);
    step("rej2", 1'b1, 1'b0, 1'b0);
    idle("retrig_win", ACYC + 2);

    // Locked at 3: simultaneous pulses are neutral, a lone entry is rejected.
    step("exit_to3", 1'b0, 1'b1, 1'b0);
    step("both_locked", 1'b1, 1'b1, 1'b0);
    step("rej_at3", 1'b1, 1'b0, 1'b0);
    idle("pre_rst", 2);

    // Asynchronous reset mid-alarm, checked before the next clock edge.
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    compare_now("async_rst", model_outputs());
    @(negedge CLK);
    RST_N = 1'b1;

    // Count to 3, then CLEAR together with ENTRY_P wins.
    for (int k = 0; k < 3; k++) step("to3", 1'b1, 1'b0, 1'b0);
    step("clr_entry", 1'b1, 1'b0, 1'b1);
    idle("tail", 2);

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
